// File: rtl/ddr_req_arbiter.sv
// Two-client round-robin arbiter that issues one DDR AXI request at a time and reports completion.
// Define DDR_ARB_WATCHDOG_EN to add a WAIT_DONE watchdog that aborts with ERR after WDOG_CYCLES.
module ddr_req_arbiter #(
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        C0_VALID,
  input  logic        C0_WRITE,
  input  logic [31:0] C0_ADDR,
  input  logic [3:0]  C0_LEN,
  output logic        C0_READY,
  output logic        C0_DONE,
  input  logic        C1_VALID,
  input  logic        C1_WRITE,
  input  logic [31:0] C1_ADDR,
  input  logic [3:0]  C1_LEN,
  output logic        C1_READY,
  output logic        C1_DONE,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic        M_WRITE,
  output logic [31:0] M_ADDR,
  output logic [3:0]  M_LEN,
  input  logic        M_DONE,
  output logic        GNT_ID,
  output logic        ERR,
  output logic [1:0]  DBG_STATE
);

  // Handshakes: a client holds Cn_VALID and its fields until the one-cycle Cn_READY pulse;
  // downstream M_VALID and M_* stay stable until M_READY is sampled high, then M_VALID drops.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        rr_q, rr_d;
  logic        m_valid_q, m_valid_d;
  logic        m_write_q, m_write_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [3:0]  m_len_q, m_len_d;
  logic [1:0]  ready_q, ready_d;
  logic [1:0]  done_q, done_d;
  logic        sel;

`ifdef DDR_ARB_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;
`else
  logic        unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    m_valid_d = m_valid_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_len_d   = m_len_q;
    ready_d   = 2'b00;
    done_d    = 2'b00;
    sel       = 1'b0;
`ifdef DDR_ARB_WATCHDOG_EN
    wdog_d    = wdog_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (C0_VALID || C1_VALID) begin
          // Contention goes to the round-robin pointer, otherwise to whoever is asking.
          sel          = (C0_VALID && C1_VALID) ? rr_q : C1_VALID;
          gnt_d        = sel;
          m_write_d    = sel ? C1_WRITE : C0_WRITE;
          m_addr_d     = sel ? C1_ADDR  : C0_ADDR;
          m_len_d      = sel ? C1_LEN   : C0_LEN;
          ready_d[sel] = 1'b1;
          m_valid_d    = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (M_READY) begin
          m_valid_d = 1'b0;
          state_d   = S_WAIT_DONE;
`ifdef DDR_ARB_WATCHDOG_EN
          wdog_d    = 16'd0;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (M_DONE) begin
          done_d[gnt_q] = 1'b1;
          rr_d          = ~gnt_q;
          state_d       = S_IDLE;
        end
`ifdef DDR_ARB_WATCHDOG_EN
        // A real completion on the expiry cycle takes priority over the abort.
        else if (wdog_q == WDOG_LAST) begin
          done_d[gnt_q] = 1'b1;
          err_d         = 1'b1;
          rr_d          = ~gnt_q;
          state_d       = S_IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      rr_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= 32'd0;
      m_len_q   <= 4'd0;
      ready_q   <= 2'b00;
      done_q    <= 2'b00;
`ifdef DDR_ARB_WATCHDOG_EN
      wdog_q    <= 16'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      m_valid_q <= m_valid_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_len_q   <= m_len_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
`ifdef DDR_ARB_WATCHDOG_EN
      wdog_q    <= wdog_d;
      err_q     <= err_d;
`endif
    end
  end

  assign C0_READY  = ready_q[0];
  assign C1_READY  = ready_q[1];
  assign C0_DONE   = done_q[0];
  assign C1_DONE   = done_q[1];
  assign M_VALID   = m_valid_q;
  assign M_WRITE   = m_write_q;
  assign M_ADDR    = m_addr_q;
  assign M_LEN     = m_len_q;
  assign GNT_ID    = gnt_q;
  assign DBG_STATE = state_q;
`ifdef DDR_ARB_WATCHDOG_EN
  assign ERR       = err_q;
`else
  assign ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Bench for ddr_req_arbiter: directed vector table, hand-written corner sequences, and a
// randomized run checked against a transaction-level model of the arbitration rules.
module tb_ddr_req_arbiter;

  localparam int WDOG = 8;
  localparam logic        C0W = 1'b1;
  localparam logic [31:0] C0A = 32'h0000_0100;
  localparam logic [3:0]  C0L = 4'd3;
  localparam logic        C1W = 1'b0;
  localparam logic [31:0] C1A = 32'h0000_0300;
  localparam logic [3:0]  C1L = 4'd2;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        C0_VALID, C0_WRITE, C0_READY, C0_DONE;
  logic [31:0] C0_ADDR;
  logic [3:0]  C0_LEN;
  logic        C1_VALID, C1_WRITE, C1_READY, C1_DONE;
  logic [31:0] C1_ADDR;
  logic [3:0]  C1_LEN;
  logic        M_VALID, M_READY, M_WRITE, M_DONE, GNT_ID, ERR;
  logic [31:0] M_ADDR;
  logic [3:0]  M_LEN;
  logic [1:0]  DBG_STATE;

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];

  always #5 ACLK = ~ACLK;

  ddr_req_arbiter #(.WDOG_CYCLES(WDOG)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .C0_VALID(C0_VALID), .C0_WRITE(C0_WRITE), .C0_ADDR(C0_ADDR), .C0_LEN(C0_LEN),
    .C0_READY(C0_READY), .C0_DONE(C0_DONE),
    .C1_VALID(C1_VALID), .C1_WRITE(C1_WRITE), .C1_ADDR(C1_ADDR), .C1_LEN(C1_LEN),
    .C1_READY(C1_READY), .C1_DONE(C1_DONE),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_WRITE(M_WRITE), .M_ADDR(M_ADDR),
    .M_LEN(M_LEN), .M_DONE(M_DONE), .GNT_ID(GNT_ID), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  typedef struct {
    bit rst, v0, v1, mr, md;
    bit r0, r1, d0, d1, mv, gnt, mf;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit rst, v0, v1, mr, md, r0, r1, d0, d1, mv, gnt, mf);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.mr = mr; v.md = md;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.mv = mv; v.gnt = gnt; v.mf = mf;
    tbl.push_back(v);
  endfunction

  // ---------------- clock/reset and driver tasks ----------------
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input bit v0, v1, mr, md);
    C0_VALID = v0; C1_VALID = v1; M_READY = mr; M_DONE = md;
  endtask

  task automatic fixed_fields();
    C0_WRITE = C0W; C0_ADDR = C0A; C0_LEN = C0L;
    C1_WRITE = C1W; C1_ADDR = C1A; C1_LEN = C1L;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    ARESETn = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit r0, r1, d0, d1, mv, gnt, er);
    chk({tag, " C0_READY"}, 64'(C0_READY), 64'(r0));
    chk({tag, " C1_READY"}, 64'(C1_READY), 64'(r1));
    chk({tag, " C0_DONE"},  64'(C0_DONE),  64'(d0));
    chk({tag, " C1_DONE"},  64'(C1_DONE),  64'(d1));
    chk({tag, " M_VALID"},  64'(M_VALID),  64'(mv));
    chk({tag, " GNT_ID"},   64'(GNT_ID),   64'(gnt));
    chk({tag, " ERR"},      64'(ERR),      64'(er));
  endtask

  task automatic check_m(input string tag, input logic w, input logic [31:0] a, input logic [3:0] l);
    chk({tag, " M_WRITE"}, 64'(M_WRITE), 64'(w));
    chk({tag, " M_ADDR"},  64'(M_ADDR),  64'(a));
    chk({tag, " M_LEN"},   64'(M_LEN),   64'(l));
  endtask

  // ---------------- randomized run with reference model ----------------
  task automatic random_run(input int cycles);
    bit [1:0]    cv, cw, rdy_seen, exp_r, exp_d;
    logic [31:0] ca[2];
    logic [3:0]  cl[2];
    bit          m_busy, m_issued, m_owner, m_rr, pick, exp_err;
    logic        m_w;
    logic [31:0] m_a;
    logic [3:0]  m_l;
    int          m_wait;
    logic [37:0] rec;
    do_reset();
    cv = '0; cw = '0; rdy_seen = '0; ca[0] = '0; ca[1] = '0; cl[0] = '0; cl[1] = '0;
    m_busy = 0; m_issued = 0; m_owner = 0; m_rr = 0; m_wait = 0;
    m_w = 0; m_a = '0; m_l = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (cv[n] && (rdy_seen[n] || $urandom_range(0, 15) == 0)) cv[n] = 1'b0;
        if (!cv[n] && $urandom_range(0, 2) == 0) begin
          cv[n] = 1'b1; cw[n] = 1'($urandom); ca[n] = $urandom; cl[n] = 4'($urandom);
        end
      end
      C0_WRITE = cw[0]; C0_ADDR = ca[0]; C0_LEN = cl[0];
      C1_WRITE = cw[1]; C1_ADDR = ca[1]; C1_LEN = cl[1];
      drive(cv[0], cv[1], 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      // One transaction at a time; contention resolved by the pointer, which names the
      // client that did not own the port last.
      exp_r = '0; exp_d = '0; exp_err = 0;
      if (!m_busy) begin
        if (cv != 2'b00) begin
          pick = (cv == 2'b11) ? m_rr : cv[1];
          m_busy = 1; m_issued = 0; m_owner = pick; exp_r[pick] = 1'b1;
          m_w = cw[pick]; m_a = ca[pick]; m_l = cl[pick];
          exp_q.push_back({pick, m_w, m_a, m_l});
        end
      end else if (!m_issued) begin
        if (M_READY) begin m_issued = 1; m_wait = 0; end
      end else begin
        m_wait++;
        if (M_DONE) begin
          exp_d[m_owner] = 1'b1; m_busy = 0; m_rr = !m_owner;
        end
`ifdef DDR_ARB_WATCHDOG_EN
        else if (m_wait == WDOG) begin
          exp_d[m_owner] = 1'b1; exp_err = 1; m_busy = 0; m_rr = !m_owner;
        end
`endif
      end
      tick();
      check_out("rnd", exp_r[0], exp_r[1], exp_d[0], exp_d[1], m_busy && !m_issued, m_owner, exp_err);
      check_m("rnd", m_w, m_a, m_l);
      if (C0_READY || C1_READY) begin
        if (exp_q.size() == 0) chk("rnd unexpected grant", 64'(1), 64'(0));
        else begin
          rec = exp_q.pop_front();
          chk("rnd grant record", 64'({GNT_ID, M_WRITE, M_ADDR, M_LEN}), 64'(rec));
        end
      end
      rdy_seen = {C1_READY, C0_READY};
    end
    chk("rnd leftover grants", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit g;
    ARESETn = 1'b0;
    drive(0, 0, 0, 0);
    fixed_fields();
    tick();
    check_out("reset", 0, 0, 0, 0, 0, 0, 0);
    check_m("reset", 0, 32'd0, 4'd0);
    chk("reset DBG_STATE", 64'(DBG_STATE), 64'(0));
    ARESETn = 1'b1;

    // Single C0 write, completion 10 edges after the grant edge.
    add(1, 1, 0, 1, 0,  1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0);
    // Simultaneous requests from reset, then both held valid: grants alternate.
    add(1, 1, 1, 1, 0,  1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1,  0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0,  0, 1, 0, 0, 1, 1, 1);
    g = 1'b1;
    for (int k = 0; k < 3; k++) begin
      add(0, 1, 1, 1, 0,  0, 0, 0, 0, 0, g, g);
      add(0, 1, 1, 1, 1,  0, 0, !g, g, 0, g, g);
      g = !g;
      add(0, 1, 1, 1, 0,  !g, g, 0, 0, 1, g, g);
    end
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].v0, tbl[i].v1, tbl[i].mr, tbl[i].md);
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1,
                tbl[i].mv, tbl[i].gnt, 0);
      if (tbl[i].mf) check_m($sformatf("vec%0d", i), C1W, C1A, C1L);
      else           check_m($sformatf("vec%0d", i), C0W, C0A, C0L);
    end

    // Downstream stall: request must stay stable, stray M_DONE in ISSUE ignored.
    do_reset();
    C1_WRITE = 1'b1; C1_ADDR = 32'hABCD_0040; C1_LEN = 4'd15;
    drive(0, 1, 0, 0); tick();
    check_out("stall grant", 0, 1, 0, 0, 1, 1, 0);
    C1_ADDR = 32'hDEAD_BEEF; C1_WRITE = 1'b0; C1_LEN = 4'd1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, i[0]); tick();
      check_out("stall hold", 0, 0, 0, 0, 1, 1, 0);
      check_m("stall hold", 1'b1, 32'hABCD_0040, 4'd15);
    end
    drive(0, 0, 1, 0); tick();
    check_out("stall accept", 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1); tick();
    check_out("stall done", 0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0); tick();
    check_out("stall after", 0, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset while waiting for completion.
    fixed_fields();
    do_reset();
    drive(1, 0, 1, 0); tick();
    check_out("rstw grant", 1, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0); tick(); tick();
    ARESETn = 1'b0;
    #1;
    check_out("rstw async", 0, 0, 0, 0, 0, 0, 0);
    check_m("rstw async", 0, 32'd0, 4'd0);
    drive(0, 0, 0, 1); tick();
    check_out("rstw held", 0, 0, 0, 0, 0, 0, 0);
    ARESETn = 1'b1;
    drive(0, 1, 0, 0); tick();
    check_out("rstw c1 grant", 0, 1, 0, 0, 1, 1, 0);
    check_m("rstw c1 grant", C1W, C1A, C1L);
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 1); tick();
    check_out("rstw c1 done", 0, 0, 0, 1, 0, 1, 0);

    // Stray M_DONE in IDLE: no completion, pointer untouched.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1); tick();
      check_out("stray idle", 0, 0, 0, 0, 0, 0, 0);
    end
    drive(1, 1, 0, 0); tick();
    check_out("stray rr0", 1, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 1); tick();
    check_out("stray d0", 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1); tick();
      check_out("stray idle2", 0, 0, 0, 0, 0, 0, 0);
    end
    drive(1, 1, 0, 0); tick();
    check_out("stray rr1", 0, 1, 0, 0, 1, 1, 0);
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 1); tick();
    check_out("stray d1", 0, 0, 0, 1, 0, 1, 0);

    // Watchdog abort, or indefinite wait when the watchdog is not built.
    do_reset();
    drive(1, 0, 1, 0); tick();
    check_out("wd grant", 1, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); tick();
    check_out("wd accept", 0, 0, 0, 0, 0, 0, 0);
`ifdef DDR_ARB_WATCHDOG_EN
    for (int i = 0; i < WDOG - 1; i++) begin
      drive(0, 0, 0, 0); tick();
      check_out("wd waiting", 0, 0, 0, 0, 0, 0, 0);
    end
    tick();
    check_out("wd expire", 0, 0, 1, 0, 0, 0, 1);
    drive(0, 1, 0, 0); tick();
    check_out("wd next grant", 0, 1, 0, 0, 1, 1, 0);
    drive(0, 0, 1, 0); tick();
    for (int i = 0; i < WDOG - 1; i++) begin
      drive(0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 1); tick();
    check_out("wd done wins", 0, 0, 0, 1, 0, 1, 0);
`else
    for (int i = 0; i < 3 * WDOG; i++) begin
      drive(0, 0, 0, 0); tick();
      check_out("wd none waiting", 0, 0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 1); tick();
    check_out("wd none done", 0, 0, 1, 0, 0, 0, 0);
`endif

    random_run(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_req_arbiter.md
DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WDOG_CYCLES, 256, watchdog limit in ACLK cycles; legal range 2..65535; used only under DDR_ARB_WATCHDOG_EN.
REQ-002 Ports (name, direction, width, meaning), one per line; n = 0,1 means one port per client:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset: asynchronous, active-low.
- Cn_VALID  in  1  client n request valid; held until Cn_READY.
- Cn_WRITE  in  1  client n direction: 1 = write, 0 = read.
- Cn_ADDR  in  32  client n start byte address.
- Cn_LEN  in  4  client n burst length minus 1, AXI3 encoding.
- Cn_READY  out  1  one-cycle pulse; client n request captured.
- Cn_DONE  out  1  one-cycle pulse; client n transaction finished.
- M_VALID  out  1  downstream request valid, toward the DDR AXI slave sequencer.
- M_READY  in  1  downstream accepts request.
- M_WRITE  out  1  latched direction.
- M_ADDR  out  32  latched address.
- M_LEN  out  4  latched length.
- M_DONE  in  1  downstream completion pulse (BVALID&&BREADY or RLAST&&RVALID&&RREADY upstream).
- GNT_ID  out  1  index of the client currently owning the downstream port.
- ERR  out  1  one-cycle watchdog abort pulse.

Function
REQ-003 FSM states are IDLE, ISSUE and WAIT_DONE; exactly one transaction is outstanding at a time.
REQ-004 IDLE arbitration:
- Evaluate C0_VALID/C1_VALID every cycle.
- If exactly one is high, grant it.
- If both are high, grant the client indicated by the round-robin pointer.
- If neither is high, stay in IDLE.
REQ-005 On a grant at edge t:
- Latch Cn_WRITE/ADDR/LEN into M_* and set GNT_ID = n.
- Pulse Cn_READY high for exactly cycle t+1.
- Drive M_VALID high from t+1.
- Enter ISSUE.
REQ-006 ISSUE:
- M_VALID and all M_* fields stay stable until M_READY is sampled high.
- On that edge, drop M_VALID and enter WAIT_DONE.
- M_READY sampled in IDLE or WAIT_DONE is ignored.
REQ-007 WAIT_DONE:
- On M_DONE, pulse C[GNT_ID]_DONE for one cycle.
- Set the round-robin pointer to the non-granted client.
- Return to IDLE.
- The next grant is possible no earlier than the cycle after Cn_DONE.
REQ-008 M_DONE asserted in IDLE or ISSUE is ignored and produces no Cn_DONE.
REQ-009 Minimum turnaround: Cn_VALID at edge t, M_READY tied high, M_DONE at t+k gives Cn_READY at t+1, M_VALID at t+1 only, Cn_DONE at t+k+1.
REQ-010 A client that drops Cn_VALID before its grant is not served.
- Cn_VALID during another client's ownership is held pending.
- A pending request is never lost.
REQ-011 Cn_READY and Cn_DONE are never asserted for the non-granted client; at most one of C0_* / C1_* pulses in any cycle.
REQ-012 Fairness: with both clients continuously valid, grants strictly alternate 0,1,0,1,...

Reset
REQ-013 On ARESETn low, asynchronously and regardless of state:
- State = IDLE.
- M_VALID, Cn_READY, Cn_DONE, ERR, GNT_ID = 0.
- M_WRITE/M_ADDR/M_LEN = 0.
- Round-robin pointer = client 0.
- Watchdog counter = 0.
REQ-014 Reset mid-transaction drops the in-flight transaction; no Cn_DONE or ERR is issued for it.
REQ-015 After ARESETn deasserts, the first grant may occur at the first ACLK rising edge.

Configuration
REQ-016 Macro DDR_ARB_WATCHDOG_EN defined:
- A 16-bit counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
- When it reaches WDOG_CYCLES without M_DONE, pulse C[GNT_ID]_DONE and ERR together for one cycle.
- Advance the pointer and return to IDLE.
- M_DONE on the same cycle as expiry wins: ERR stays 0.
REQ-017 Macro DDR_ARB_WATCHDOG_EN undefined:
- No counter is instantiated.
- ERR is tied to 0.
- WAIT_DONE waits indefinitely for M_DONE.

Verification
REQ-018 Bench shall cover the following directed scenarios:
- C0 write, ADDR=0x100, LEN=3, M_READY high, M_DONE 10 cycles later -> C0_READY at t+1; M_ADDR=0x100, M_LEN=3, M_WRITE=1; C0_DONE once; C1 outputs idle.
- C0 and C1 valid in the same cycle from reset -> C0 granted first, C1 granted the cycle after C0_DONE; then both held valid for 4 transactions -> GNT_ID sequence 0,1,0,1.
- M_READY held low 5 cycles during ISSUE -> M_VALID stays high, M_* unchanged; no Cn_READY repeat.
- ARESETn pulsed low in WAIT_DONE -> all outputs 0 immediately; no Cn_DONE; next request from C1 alone is granted normally.
- DDR_ARB_WATCHDOG_EN, WDOG_CYCLES=8, M_DONE never asserted -> Cn_DONE and ERR pulse after 8 WAIT_DONE cycles; FSM returns to IDLE.
- Stray M_DONE in IDLE -> no Cn_DONE; pointer unchanged.
